// File: rtl/ball_ctrl.sv
// ---------------------------------------------------------------------------
// ball_ctrl -- ball motion and rally state machine for the pong game.
//
// Consumes collision flags computed from the current ball centre and, once
// per frame strobe, produces the next ball centre. Also owns the serve
// delay, point scoring and game-over handling.
//
// Optional feature macro: BALL_SPEEDUP_EN
//   When defined, each paddle hit speeds the ball up by one pixel per frame
//   (saturating) and every point restores the base SPEED.
//
// Ports:
//   clk        in   pixel clock
//   rst        in   synchronous active-high reset
//   frame      in   one-cycle strobe per frame (start of vertical blank)
//   start      in   leaves IDLE or OVER
//   coll_h     in   ball touches left or right screen edge
//   coll_v     in   ball touches top or bottom screen edge
//   hit_l      in   ball overlaps left paddle
//   hit_r      in   ball overlaps right paddle
//   bx         out  ball centre x (10 bits)
//   by         out  ball centre y (9 bits)
//   score_l    out  left player score
//   score_r    out  right player score
//   point_l    out  one-cycle pulse, left player scored
//   point_r    out  one-cycle pulse, right player scored
//   game_over  out  high while in OVER
// ---------------------------------------------------------------------------
module ball_ctrl #(
    parameter int S_WIDTH      = 640,
    parameter int S_HEIGHT     = 480,
    parameter int SPEED        = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int MAX_SCORE    = 9
`ifdef BALL_SPEEDUP_EN
    ,
    parameter int BALL_HALF    = 8
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic       start,
    input  logic       coll_h,
    input  logic       coll_v,
    input  logic       hit_l,
    input  logic       hit_r,
    output logic [9:0] bx,
    output logic [8:0] by,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       point_l,
    output logic       point_r,
    output logic       game_over
);

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [9:0]       CX       = 10'(S_WIDTH / 2);
    localparam logic [8:0]       CY       = 9'(S_HEIGHT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [3:0]       MAX_SC   = 4'(MAX_SCORE);
    localparam logic [2:0]       BASE_STEP = 3'(SPEED);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [9:0]       bx_r, bx_s;
    logic [8:0]       by_r, by_s;
    logic [3:0]       score_l_r, score_l_s;
    logic [3:0]       score_r_r, score_r_s;
    logic             point_l_r, point_l_s;
    logic             point_r_r, point_r_s;
    logic             game_over_r, game_over_s;
    logic             dir_x_r, dir_x_s;   // 1 = moving right
    logic             dir_y_r, dir_y_s;   // 1 = moving down
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       step_s;             // step used for this frame's move

`ifdef BALL_SPEEDUP_EN
    // Largest step that stays below the ball half-size, capped by 3 bits.
    localparam logic [2:0] STEP_MAX = 3'(((BALL_HALF - 1) < 7) ? (BALL_HALF - 1) : 7);
    logic [2:0] step_r, step_next_s;
`endif

    // Next-state and next-output computation for the rally FSM.
    always_comb begin
        state_s     = state_r;
        bx_s        = bx_r;
        by_s        = by_r;
        score_l_s   = score_l_r;
        score_r_s   = score_r_r;
        point_l_s   = 1'b0;
        point_r_s   = 1'b0;
        game_over_s = game_over_r;
        dir_x_s     = dir_x_r;
        dir_y_s     = dir_y_r;
        cnt_s       = cnt_r;
`ifdef BALL_SPEEDUP_EN
        step_next_s = step_r;
`endif
        step_s      = BASE_STEP;

        case (state_r)
            ST_IDLE, ST_OVER: begin
                // A frame on the same edge as start does not count toward the serve.
                if (start) begin
                    state_s     = ST_SERVE;
                    cnt_s       = {CNT_W{1'b0}};
                    score_l_s   = 4'd0;
                    score_r_s   = 4'd0;
                    game_over_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_SERVE: begin
                if (frame) begin
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_PLAY;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_PLAY: begin
                if (frame) begin
                    // Paddle hits force direction away from the paddle; both
                    // at once leave it alone.
                    if (hit_l && !hit_r) begin
                        dir_x_s = 1'b1;
                    end else if (hit_r && !hit_l) begin
                        dir_x_s = 1'b0;
                    end else begin
                        dir_x_s = dir_x_r;
                    end

                    if (coll_v) begin
                        dir_y_s = (by_r < CY) ? 1'b1 : 1'b0;
                    end else begin
                        dir_y_s = dir_y_r;
                    end

`ifdef BALL_SPEEDUP_EN
                    if (hit_l || hit_r) begin
                        step_next_s = (step_r < STEP_MAX) ? (step_r + 3'd1) : step_r;
                    end else begin
                        step_next_s = step_r;
                    end
                    step_s = step_next_s;
`endif

                    if (!(hit_l || hit_r) && coll_h) begin
                        // Point: serve goes toward the player who conceded.
                        if (bx_r < CX) begin
                            score_r_s = (score_r_r < MAX_SC) ? (score_r_r + 4'd1) : score_r_r;
                            point_r_s = 1'b1;
                            dir_x_s   = 1'b0;
                        end else begin
                            score_l_s = (score_l_r < MAX_SC) ? (score_l_r + 4'd1) : score_l_r;
                            point_l_s = 1'b1;
                            dir_x_s   = 1'b1;
                        end
                        bx_s  = CX;
                        by_s  = CY;
                        cnt_s = {CNT_W{1'b0}};
`ifdef BALL_SPEEDUP_EN
                        step_next_s = BASE_STEP;
`endif
                        if ((score_l_s == MAX_SC) || (score_r_s == MAX_SC)) begin
                            state_s     = ST_OVER;
                            game_over_s = 1'b1;
                        end else begin
                            state_s = ST_SERVE;
                        end
                    end else begin
                        bx_s = dir_x_s ? (bx_r + {7'd0, step_s}) : (bx_r - {7'd0, step_s});
                        by_s = dir_y_s ? (by_r + {6'd0, step_s}) : (by_r - {6'd0, step_s});
                    end
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bx_r        <= CX;
            by_r        <= CY;
            score_l_r   <= 4'd0;
            score_r_r   <= 4'd0;
            point_l_r   <= 1'b0;
            point_r_r   <= 1'b0;
            game_over_r <= 1'b0;
            dir_x_r     <= 1'b1;
            dir_y_r     <= 1'b1;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            bx_r        <= bx_s;
            by_r        <= by_s;
            score_l_r   <= score_l_s;
            score_r_r   <= score_r_s;
            point_l_r   <= point_l_s;
            point_r_r   <= point_r_s;
            game_over_r <= game_over_s;
            dir_x_r     <= dir_x_s;
            dir_y_r     <= dir_y_s;
            cnt_r       <= cnt_s;
        end
    end

`ifdef BALL_SPEEDUP_EN
    // Per-rally step register for the speed-up feature.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r <= BASE_STEP;
        end else begin
            step_r <= step_next_s;
        end
    end
`endif

    assign bx        = bx_r;
    assign by        = by_r;
    assign score_l   = score_l_r;
    assign score_r   = score_r_r;
    assign point_l   = point_l_r;
    assign point_r   = point_r_r;
    assign game_over = game_over_r;

endmodule

// File: tb/tb_ball_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_ctrl -- directed self-checking bench for ball_ctrl (default build).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_ball_ctrl;

    logic       clk;
    logic       rst;
    logic       frame;
    logic       start;
    logic       coll_h;
    logic       coll_v;
    logic       hit_l;
    logic       hit_r;
    logic [9:0] bx;
    logic [8:0] by;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       point_l;
    logic       point_r;
    logic       game_over;

    int checks_r = 0;
    int errors_r = 0;

    ball_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .frame     (frame),
        .start     (start),
        .coll_h    (coll_h),
        .coll_v    (coll_v),
        .hit_l     (hit_l),
        .hit_r     (hit_r),
        .bx        (bx),
        .by        (by),
        .score_l   (score_l),
        .score_r   (score_r),
        .point_l   (point_l),
        .point_r   (point_r),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            errors_r = errors_r + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame strobe with the given collision flags held for that cycle.
    task automatic do_frame(input logic h, input logic v, input logic l, input logic r);
        @(negedge clk);
        frame  = 1'b1;
        coll_h = h;
        coll_v = v;
        hit_l  = l;
        hit_r  = r;
        @(negedge clk);
        frame  = 1'b0;
        coll_h = 1'b0;
        coll_v = 1'b0;
        hit_l  = 1'b0;
        hit_r  = 1'b0;
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) begin
            do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int ex, input int ey);
        chk_eq({tag, "_bx"}, 32'(bx), 32'(ex));
        chk_eq({tag, "_by"}, 32'(by), 32'(ey));
    endtask

    initial begin
        rst    = 1'b1;
        frame  = 1'b0;
        start  = 1'b0;
        coll_h = 1'b0;
        coll_v = 1'b0;
        hit_l  = 1'b0;
        hit_r  = 1'b0;

        // Reset with frames running.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            frame = ~frame;
        end
        @(negedge clk);
        rst   = 1'b0;
        frame = 1'b0;
        chk_pos("reset", 320, 240);
        chk_eq("reset_score_l", 32'(score_l), 32'd0);
        chk_eq("reset_score_r", 32'(score_r), 32'd0);
        chk_eq("reset_game_over", 32'(game_over), 32'd0);
        chk_eq("reset_point_l", 32'(point_l), 32'd0);

        idle_frames(10);
        chk_pos("idle_hold", 320, 240);

        // start together with a frame: that frame does not count.
        @(negedge clk);
        start = 1'b1;
        frame = 1'b1;
        @(negedge clk);
        start = 1'b0;
        frame = 1'b0;
        idle_frames(60);
        chk_pos("serve_hold60", 320, 240);
        idle_frames(1);
        chk_pos("first_move", 322, 242);

        // Bottom half wall bounce sends the ball up.
        do_frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk_pos("vbounce_down", 324, 240);
        idle_frames(118);
        chk_pos("near_top", 560, 4);
        do_frame(1'b0, 1'b1, 1'b0, 1'b0);
        chk_pos("vbounce_top", 562, 6);
        chk_eq("vbounce_no_pt_l", 32'(point_l), 32'd0);
        chk_eq("vbounce_no_pt_r", 32'(point_r), 32'd0);

        // Right paddle held for three frames: ball keeps moving left.
        idle_frames(19);
        chk_pos("at_600", 600, 44);
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        chk_pos("hit_r_1", 598, 46);
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        chk_pos("hit_r_2", 596, 48);
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        chk_pos("hit_r_3", 594, 50);

        // Edge and paddle together: bounce wins, no point.
        do_frame(1'b1, 1'b0, 1'b1, 1'b0);
        chk_pos("hit_beats_edge", 596, 52);
        chk_eq("hit_beats_edge_pt", 32'(point_l), 32'd0);
        chk_eq("hit_beats_edge_sc", 32'(score_l), 32'd0);

        // Right-half edge: left player scores.
        do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("left_pt_pulse", 32'(point_l), 32'd1);
        chk_eq("left_pt_other", 32'(point_r), 32'd0);
        chk_eq("left_pt_score", 32'(score_l), 32'd1);
        chk_pos("left_pt_centre", 320, 240);
        @(negedge clk);
        chk_eq("left_pt_one_cycle", 32'(point_l), 32'd0);

        idle_frames(60);
        chk_pos("serve2_hold", 320, 240);
        do_frame(1'b0, 1'b0, 1'b0, 1'b1);
        chk_pos("serve2_hit_r", 318, 242);

        // Left-half edge: right player scores, next serve heads left.
        do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("right_pt_pulse", 32'(point_r), 32'd1);
        chk_eq("right_pt_score", 32'(score_r), 32'd1);
        chk_pos("right_pt_centre", 320, 240);
        @(negedge clk);
        chk_eq("right_pt_one_cycle", 32'(point_r), 32'd0);
        idle_frames(61);
        chk_pos("serve3_dir_left", 318, 242);

        // start during PLAY is ignored.
        pulse_start();
        do_frame(1'b0, 1'b0, 1'b0, 1'b0);
        chk_pos("start_in_play", 316, 244);
        chk_eq("start_in_play_sc", 32'(score_r), 32'd1);

        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        do_frame(1'b0, 1'b0, 1'b1, 1'b0);
        chk_pos("hit_l_twice", 320, 248);
        do_frame(1'b1, 1'b0, 1'b0, 1'b0);
        chk_eq("left_pt2_score", 32'(score_l), 32'd2);

        // Left player runs the score up to the game-ending value.
        for (int i = 0; i < 7; i++) begin
            idle_frames(60);
            do_frame(1'b0, 1'b0, 1'b0, 1'b0);
            chk_pos("rally_move", 322, 242);
            do_frame(1'b1, 1'b0, 1'b0, 1'b0);
            chk_eq("rally_score_l", 32'(score_l), 32'(i + 3));
            chk_eq("rally_game_over", 32'(game_over), (i == 6) ? 32'd1 : 32'd0);
            chk_pos("rally_centre", 320, 240);
        end

        // OVER holds everything until start.
        for (int i = 0; i < 5; i++) begin
            do_frame(1'b1, 1'b1, 1'b1, 1'b0);
        end
        chk_eq("over_score_l", 32'(score_l), 32'd9);
        chk_eq("over_score_r", 32'(score_r), 32'd1);
        chk_eq("over_flag", 32'(game_over), 32'd1);
        chk_pos("over_centre", 320, 240);

        pulse_start();
        chk_eq("restart_score_l", 32'(score_l), 32'd0);
        chk_eq("restart_score_r", 32'(score_r), 32'd0);
        chk_eq("restart_game_over", 32'(game_over), 32'd0);
        idle_frames(60);
        chk_pos("restart_hold", 320, 240);
        idle_frames(1);
        chk_pos("restart_move", 322, 242);

        // Reset mid-play.
        @(negedge clk);
        rst   = 1'b1;
        frame = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        frame = 1'b0;
        chk_pos("midreset", 320, 240);
        idle_frames(10);
        chk_pos("midreset_idle", 320, 240);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule

// File: doc/ball_ctrl.md
Name: ball_ctrl

Overview:
- Ball motion and rally state machine for the pong game.
- Sits directly downstream of the collision stages: consumes wall-collision flags (horizontal/vertical) and per-paddle collision flags computed from its own current ball centre, and produces the next ball centre once per frame.
- Also owns serve delay, point scoring and game-over.
- Its bx/by outputs feed back into the collision checkers and into the renderer.

Parameters:
- S_WIDTH, 640, screen width in pixels
- S_HEIGHT, 480, screen height in pixels
- SPEED, 2, ball step per frame per axis in pixels; must be 1..7 and less than ball half-size
- SERVE_FRAMES, 60, frames the ball is held at centre before a serve
- MAX_SCORE, 9, score that ends the game

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- frame  in  1  one-cycle strobe, once per frame (start of vertical blank)
- start  in  1  level/pulse; leaves IDLE or OVER
- coll_h  in  1  ball touches left or right screen edge
- coll_v  in  1  ball touches top or bottom screen edge
- hit_l  in  1  ball overlaps left paddle
- hit_r  in  1  ball overlaps right paddle
- bx  out  10  ball centre x
- by  out  9  ball centre y
- score_l  out  4  left player score
- score_r  out  4  right player score
- point_l  out  1  one-cycle pulse, left player scored
- point_r  out  1  one-cycle pulse, right player scored
- game_over  out  1  high while in OVER

Behaviour:
- Reset: one clock; synchronous active-high reset on rst.
- Reset values: bx=S_WIDTH/2 (320), by=S_HEIGHT/2 (240), scores 0, pulses 0, game_over 0, dir_x=+ (right), dir_y=+ (down), serve counter 0, state IDLE.
- Reset mid-operation returns everything to reset values on the next edge, regardless of state.
- All state changes other than start handling occur only on clk edges where frame=1. Inputs are sampled on that edge; they reflect the current bx/by. Position updates one cycle after the frame edge is visible on bx/by.
- IDLE: ball held at centre. start=1 -> SERVE, counter cleared, scores cleared.
- SERVE: ball held at centre. Each frame increments the counter. When counter reaches SERVE_FRAMES-1 on a frame edge -> PLAY, so the first move happens on the next frame (SERVE_FRAMES frames of hold).
- PLAY, per frame, evaluated in this priority order:
  1. hit_l -> dir_x=+ ; hit_r -> dir_x=- (direction forced away from the paddle, never toggled, so no sticking). Both set -> dir_x unchanged.
  2. Else coll_h -> point scored:
     - bx < S_WIDTH/2: right player scores (score_r+1, point_r pulse).
     - Otherwise left scores.
     - Ball returns to centre.
     - Next serve dir_x points toward the player who conceded; dir_y is kept.
     - New score == MAX_SCORE -> OVER, else -> SERVE with counter 0. No move this frame.
  3. coll_v is independent of steps 1-2: by < S_HEIGHT/2 -> dir_y=+ , else dir_y=-.
  4. If no point: bx += / -= SPEED, by += / -= SPEED, using the updated directions.
- Width rules: all arithmetic unsigned, 10-bit x and 9-bit y. SPEED below the ball half-size guarantees no underflow or overflow, since edge collision fires first.
- Point pulses: last exactly one clk cycle, coincident with the frame edge that scored.
- Scores: saturate at MAX_SCORE and never wrap.
- OVER: ball at centre, game_over=1, scores held. start=1 -> scores 0, game_over 0, -> SERVE.
- start during SERVE/PLAY: ignored.
- frame and start on the same edge in IDLE/OVER: the transition happens and the frame does not count toward serve.

Optional Feature:
- Macro: BALL_SPEEDUP_EN.
- With it defined:
  - Adds a 3-bit step register, reset to SPEED.
  - Each paddle hit (step 1 taken) increments step by 1, saturating at 7 and never exceeding ball half-size minus 1.
  - Reset to SPEED on every point.
  - Movement uses step instead of SPEED.
- Without it: step is the constant SPEED and no register is built.

Test Plan:
- Reset with frames running -> bx=320, by=240, scores 0, state IDLE; ball does not move over 10 frames.
- start, then 60 frames -> ball static at (320,240) through frame 60; frame 61 -> (322,242).
- PLAY moving up (dir_y=-) at by=5 with coll_v=1 on a frame -> dir_y=+, by=7 next frame; no point pulse.
- hit_r=1 with dir_x=+ at bx=600 -> bx=598. Hold hit_r for 3 frames -> bx keeps decreasing (598, 596, 594), no oscillation.
- coll_h=1 at bx=4 -> point_r one cycle, score_r=1, ball at (320,240), state SERVE, next serve dir_x=- ; coll_h with hit_l both set -> bounce, no point.
- score_l at 8 plus left point -> score_l=9, game_over=1, ball centred. Further frames do nothing. start -> scores 0, game_over 0, SERVE.
- With BALL_SPEEDUP_EN and SPEED=2: three paddle hits -> per-frame step of 3, 4, 5 px; after a point the step returns to 2.
